// File: rtl/md_issue_ctrl_pkg.sv
// Shared types and constants for the mult/div issue controller.
package md_pkg;

  localparam int unsigned MD_OP_W      = 4;
  localparam int unsigned MULT_CTR_W   = 3;
  localparam int unsigned MULT_LAT_DEF = 5;
  localparam int unsigned DIV_LAT_DEF  = 10;
  localparam int unsigned CNT_W_DEF    = 4;

  // HI/LO instruction class carried down the pipeline
  typedef enum logic [MD_OP_W-1:0] {
    MD_NONE = 4'd0,
    MULTU   = 4'd1,
    MULT    = 4'd2,
    DIVU    = 4'd3,
    DIV     = 4'd4,
    MTHI    = 4'd5,
    MTLO    = 4'd6,
    MFHI    = 4'd7,
    MFLO    = 4'd8
  } md_op_t;

  // operation codes understood by mod_mult
  localparam logic [MULT_CTR_W-1:0] MC_MULTU = 3'd0;
  localparam logic [MULT_CTR_W-1:0] MC_MULT  = 3'd1;
  localparam logic [MULT_CTR_W-1:0] MC_DIVU  = 3'd2;
  localparam logic [MULT_CTR_W-1:0] MC_DIV   = 3'd3;
  localparam logic [MULT_CTR_W-1:0] MC_MTHI  = 3'd4;
  localparam logic [MULT_CTR_W-1:0] MC_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_DRAIN = 2'd2
  } md_state_t;

endpackage

// File: rtl/md_issue_ctrl_if.sv
// Hazard-unit side bundle of the mult/div issue controller.
interface md_issue_ctrl_if;

  md_pkg::md_op_t md_op_D;
  md_pkg::md_op_t md_op_E;
  logic           flush_E;
  logic           md_busy;
  logic           start;
  logic [2:0]     mult_ctr;
  logic           stall;
  logic           ctrl_busy;
  logic           issue_err;

  modport master (
    output md_op_D, md_op_E, flush_E, md_busy,
    input  start, mult_ctr, stall, ctrl_busy, issue_err
  );

  modport slave (
    input  md_op_D, md_op_E, flush_E, md_busy,
    output start, mult_ctr, stall, ctrl_busy, issue_err
  );

endinterface

// File: rtl/md_issue_ctrl.sv
// Issues E-stage mult/div/mthi/mtlo to mod_mult, tracks unit occupancy and
// stalls D-stage HI/LO instructions that would collide with it.
module md_issue_ctrl
  import md_pkg::*;
#(
  parameter int unsigned MULT_LAT = MULT_LAT_DEF,
  parameter int unsigned DIV_LAT  = DIV_LAT_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  md_issue_ctrl_if.slave   bus
);

  md_state_t               state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    err_q, err_d;

  logic                    long_op;
  logic                    wr_op;
  logic                    div_op;
  logic [MULT_CTR_W-1:0]   op_code;
  logic                    issue;

  // E-stage class decode
  always_comb begin
    long_op = 1'b0;
    wr_op   = 1'b0;
    div_op  = 1'b0;
    op_code = MC_MULTU;
    case (bus.md_op_E)
      MULTU: begin long_op = 1'b1; op_code = MC_MULTU; end
      MULT:  begin long_op = 1'b1; op_code = MC_MULT;  end
      DIVU:  begin long_op = 1'b1; div_op = 1'b1; op_code = MC_DIVU; end
      DIV:   begin long_op = 1'b1; div_op = 1'b1; op_code = MC_DIV;  end
      MTHI:  begin wr_op = 1'b1; op_code = MC_MTHI; end
      MTLO:  begin wr_op = 1'b1; op_code = MC_MTLO; end
      default: ;
    endcase
  end

  // Next-state, latency counter and sticky protocol-error flag
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    issue   = (long_op | wr_op) & ~bus.flush_E & (state_q == S_IDLE) & ~reset;

    case (state_q)
      S_IDLE: begin
        if (issue && long_op) begin
          state_d = S_BUSY;
          cnt_d   = div_op ? CNT_W'(DIV_LAT - 1) : CNT_W'(MULT_LAT - 1);
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) begin
          state_d = bus.md_busy ? S_DRAIN : S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DRAIN: begin
        if (!bus.md_busy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // an unflushed issue attempt while occupied is dropped and flagged
    if ((long_op || wr_op) && !bus.flush_E && (state_q != S_IDLE)) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // start/stall are same-cycle so the E-stage op and its D-stage follower see them
  assign bus.start     = issue;
  assign bus.mult_ctr  = issue ? op_code : '0;
  assign bus.stall     = ~reset & (bus.md_op_D != MD_NONE) &
                         ((state_q != S_IDLE) | (issue & long_op));
  assign bus.ctrl_busy = ~reset & (state_q != S_IDLE);
  assign bus.issue_err = err_q;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed-vector bench for md_issue_ctrl.
module tb_md_issue_ctrl;
  import md_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  md_issue_ctrl_if bus ();

  md_issue_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, act, exp);
    end
  endtask

  // checks one cycle's outputs mid-cycle, then advances to just after the next edge
  task automatic cyc(input string tag, input logic s, input logic [2:0] c,
                     input logic st, input logic b, input logic e);
    @(negedge clk);
    check({tag, ".start"},     32'(bus.start),     32'(s));
    check({tag, ".mult_ctr"},  32'(bus.mult_ctr),  32'(c));
    check({tag, ".stall"},     32'(bus.stall),     32'(st));
    check({tag, ".ctrl_busy"}, 32'(bus.ctrl_busy), 32'(b));
    check({tag, ".issue_err"}, 32'(bus.issue_err), 32'(e));
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input md_op_t d, input md_op_t e, input logic fl, input logic mb);
    bus.md_op_D = d;
    bus.md_op_E = e;
    bus.flush_E = fl;
    bus.md_busy = mb;
  endtask

  initial begin
    reset = 1'b1;
    drive(MFLO, MULT, 1'b0, 1'b0);
    @(posedge clk);
    #1;

    // reset held with a MULT sitting in E
    for (int i = 0; i < 3; i++) cyc("rst", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    // MULT issue with MFLO behind it
    drive(MFLO, MULT, 1'b0, 1'b0);
    cyc("mult_issue", 1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
    drive(MFLO, MD_NONE, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc("mult_busy", 1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
    cyc("mult_done", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);

    // DIVU with MTHI in D
    drive(MTHI, DIVU, 1'b0, 1'b0);
    cyc("divu_issue", 1'b1, 3'd2, 1'b1, 1'b0, 1'b0);
    drive(MTHI, MD_NONE, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cyc("divu_busy", 1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
    cyc("divu_done", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);

    // flushed DIV never issues
    drive(MFHI, DIV, 1'b1, 1'b0);
    cyc("div_flush", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    drive(MFHI, MD_NONE, 1'b0, 1'b0);
    cyc("div_flush_after", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);

    // MFHI in E never issues
    drive(MD_NONE, MFHI, 1'b0, 1'b0);
    cyc("mfhi_e", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);

    // MULTU with mod_mult still busy past counter expiry -> DRAIN
    drive(MFLO, MULTU, 1'b0, 1'b0);
    cyc("multu_issue", 1'b1, 3'd0, 1'b1, 1'b0, 1'b0);
    drive(MFLO, MD_NONE, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cyc("multu_busy", 1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) cyc("multu_drain", 1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
    drive(MFLO, MD_NONE, 1'b0, 1'b0);
    cyc("multu_drain_last", 1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
    cyc("multu_done", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);

    // MTLO is a single-cycle write
    drive(MD_NONE, MTLO, 1'b0, 1'b0);
    cyc("mtlo_issue", 1'b1, 3'd5, 1'b0, 1'b0, 1'b0);
    drive(MD_NONE, MD_NONE, 1'b0, 1'b0);
    cyc("mtlo_after", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);

    // MULT forced into E while busy -> dropped, sticky error
    drive(MD_NONE, MULT, 1'b0, 1'b0);
    cyc("viol_issue", 1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
    cyc("viol_hit", 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    drive(MFHI, MD_NONE, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc("viol_busy", 1'b0, 3'd0, 1'b1, 1'b1, 1'b1);
    cyc("viol_sticky", 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);

    // flush during BUSY does not cancel the running op
    drive(MD_NONE, MULT, 1'b0, 1'b0);
    cyc("flushbusy_issue", 1'b1, 3'd1, 1'b0, 1'b0, 1'b1);
    drive(MD_NONE, MD_NONE, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cyc("flushbusy_busy", 1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
    drive(MD_NONE, MD_NONE, 1'b0, 1'b0);
    cyc("flushbusy_done", 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);

    // reset clears error, then reset pulsed mid-BUSY
    reset = 1'b1;
    cyc("rst2", 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    reset = 1'b0;
    drive(MFLO, DIV, 1'b0, 1'b0);
    cyc("div_issue", 1'b1, 3'd3, 1'b1, 1'b0, 1'b0);
    drive(MFLO, MD_NONE, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) cyc("div_busy", 1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
    reset = 1'b1;
    cyc("div_rst", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    cyc("div_rst_after", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    drive(MD_NONE, MULT, 1'b0, 1'b0);
    cyc("reissue", 1'b1, 3'd1, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
